// File: rtl/apu_cmd_tx_if.sv
// Port bundle for apu_cmd_tx: requester write channel, APU PA/PB strobe lines and status.
// master is the transmitter itself; slave is the requester / APU side that drives its inputs.
interface apu_cmd_tx_if;
    logic       CE;
    logic       EN;
    logic [7:0] WR_DATA;
    logic       WR_LAST;
    logic       WR_VALID;
    logic       WR_READY;
    logic [7:0] PA_O;
    logic       PA_OE;
    logic       SCPUB;
    logic       WRB;
    logic       ACK_I;
    logic       BUSY;
    logic       PKT_DONE;
    logic       ERR;

    modport master (
        input  CE, EN, WR_DATA, WR_LAST, WR_VALID, ACK_I,
        output WR_READY, PA_O, PA_OE, SCPUB, WRB, BUSY, PKT_DONE, ERR
    );

    modport slave (
        output CE, EN, WR_DATA, WR_LAST, WR_VALID, ACK_I,
        input  WR_READY, PA_O, PA_OE, SCPUB, WRB, BUSY, PKT_DONE, ERR
    );
endinterface

// File: rtl/apu_cmd_tx.sv
// Host-side uPD1771C command transmitter: FIFO-buffered bytes replayed with the CPU's PA/SCPUB/WRB/ACK handshake.
// Define APU_TX_TIMEOUT_EN to add per-phase acknowledge timeouts, packet drop and a sticky ERR flag.
module apu_cmd_tx #(
    parameter int DEPTH         = 8,
    parameter int SETUP_TICKS   = 2,
    parameter int STROBE_TICKS  = 4,
    parameter int TIMEOUT_TICKS = 1023
) (
    input  logic         CLK,
    input  logic         RES,
    apu_cmd_tx_if.master bus
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [10:0] SETUP_LIM  = 11'(SETUP_TICKS);
    localparam logic [10:0] STROBE_LIM = 11'(STROBE_TICKS);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_STROBE   = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;
`ifdef APU_TX_TIMEOUT_EN
    localparam logic [2:0]  S_FLUSH     = 3'd5;
    localparam logic [10:0] TIMEOUT_LIM = 11'(TIMEOUT_TICKS);
`endif

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apu_cmd_tx: DEPTH must be a power of two in 2..64");
    end
    if (SETUP_TICKS < 1 || SETUP_TICKS > 1023 || STROBE_TICKS < 1 || STROBE_TICKS > 1023) begin : g_bad_ticks
        $error("apu_cmd_tx: SETUP_TICKS and STROBE_TICKS must be in 1..1023");
    end
    if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 1023) begin : g_bad_timeout
        $error("apu_cmd_tx: TIMEOUT_TICKS must be in 1..1023");
    end

    logic [8:0]  fifo_mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] used;
    logic [AW:0] used_next;
    logic        fifo_empty;
    logic [8:0]  head;
    logic        push;
    logic        pop;
    logic        start;
    logic        wr_ready_q;

    logic [2:0]  state;
    logic [9:0]  cnt;
    logic [10:0] cnt_inc;
    logic [9:0]  cnt_sat;
    logic        ack_s1;
    logic        ack_sync;
    logic        cur_last;

    logic [7:0]  pa_q;
    logic        pa_oe_q;
    logic        scpub_q;
    logic        wrb_q;
    logic        pkt_done_q;

    assign used       = wr_ptr - rd_ptr;
    assign fifo_empty = (used == '0);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];
    assign push       = bus.WR_VALID & wr_ready_q;
    assign start      = (state == S_IDLE) & bus.EN & ~fifo_empty & ~ack_sync;

`ifdef APU_TX_TIMEOUT_EN
    assign pop = start | ((state == S_FLUSH) & ~fifo_empty);
`else
    assign pop = start;
`endif

    assign used_next = used + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign cnt_inc   = {1'b0, cnt} + {10'd0, bus.CE};
    assign cnt_sat   = cnt_inc[10] ? 10'h3FF : cnt_inc[9:0];

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {bus.WR_LAST, bus.WR_DATA};
        end
    end

    // WR_READY is registered, so a pop freeing the last slot only reopens the port next cycle.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
            wr_ready_q <= (used_next != FULL_CNT);
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ack_s1   <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_s1   <= bus.ACK_I;
            ack_sync <= ack_s1;
        end
    end

`ifdef APU_TX_TIMEOUT_EN
    logic timeout_hit;
    logic err_q;

    assign timeout_hit = (((state == S_WAIT_ACK) & ~ack_sync) | ((state == S_RELEASE) & ack_sync))
                         & (cnt_inc >= TIMEOUT_LIM);
`endif

    // A CE on an ack-driven or start transition is the first tick of the new phase;
    // a CE that completes a tick count belongs to the phase it ends, so the next count starts at 0.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cur_last   <= 1'b0;
            pa_q       <= '0;
            pa_oe_q    <= 1'b0;
            scpub_q    <= 1'b1;
            wrb_q      <= 1'b1;
            pkt_done_q <= 1'b0;
`ifdef APU_TX_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            pkt_done_q <= 1'b0;
`ifdef APU_TX_TIMEOUT_EN
            if (timeout_hit) begin
                err_q   <= 1'b1;
                wrb_q   <= 1'b1;
                scpub_q <= 1'b1;
                pa_oe_q <= 1'b0;
                cnt     <= '0;
                state   <= cur_last ? S_IDLE : S_FLUSH;
            end else
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pa_q     <= head[7:0];
                        cur_last <= head[8];
                        pa_oe_q  <= 1'b1;
                        scpub_q  <= 1'b0;
                        cnt      <= {9'd0, bus.CE};
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_inc >= SETUP_LIM) begin
                        wrb_q <= 1'b0;
                        cnt   <= '0;
                        state <= S_STROBE;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                S_STROBE: begin
                    if (cnt_inc >= STROBE_LIM) begin
                        cnt   <= '0;
                        state <= S_WAIT_ACK;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                S_WAIT_ACK: begin
                    if (ack_sync) begin
                        wrb_q <= 1'b1;
                        cnt   <= {9'd0, bus.CE};
                        state <= S_RELEASE;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
                S_RELEASE: begin
                    if (!ack_sync) begin
                        scpub_q    <= 1'b1;
                        pa_oe_q    <= 1'b0;
                        pkt_done_q <= cur_last;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt_sat;
                    end
                end
`ifdef APU_TX_TIMEOUT_EN
                // Discards the remainder of the aborted packet, one entry per CLK.
                S_FLUSH: begin
                    if (fifo_empty || head[8]) begin
                        state <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.WR_READY = wr_ready_q;
    assign bus.PA_O     = pa_q;
    assign bus.PA_OE    = pa_oe_q;
    assign bus.SCPUB    = scpub_q;
    assign bus.WRB      = wrb_q;
    assign bus.PKT_DONE = pkt_done_q;
    assign bus.BUSY     = ~fifo_empty | (state != S_IDLE);
`ifdef APU_TX_TIMEOUT_EN
    assign bus.ERR      = err_q;
`else
    assign bus.ERR      = 1'b0;
`endif

endmodule
